// File: rtl/division_pkg.sv
// Shared definitions for the divider back end: default width, sign-restore
// FSM state encoding and the most negative representable magnitude.
package division_pkg;

   localparam int DIV_WIDTH = 4;

   // Magnitude of the most negative DIV_WIDTH-bit two's-complement value.
   localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/division_sign_restore_if.sv
// Bus between the divider core (master) and the sign-restore stage (slave).
interface division_sign_restore_if #(
   parameter int WIDTH = division_pkg::DIV_WIDTH
);
   logic             restore_sel;
   logic [WIDTH-1:0] quot_mag;
   logic [WIDTH-1:0] rem_mag;
   logic             first_sign;
   logic             second_sign;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             overflow;
   logic             restore_busy;
   logic             restore_finish;

   modport master (
      output restore_sel, quot_mag, rem_mag, first_sign, second_sign,
      input  quotient, remainder, overflow, restore_busy, restore_finish
   );

   modport slave (
      input  restore_sel, quot_mag, rem_mag, first_sign, second_sign,
      output quotient, remainder, overflow, restore_busy, restore_finish
   );
endinterface

// File: rtl/division_serial_negator.sv
// Bit-serial conditional two's-complement negator. The value is loaded into
// a shift register and rotated out LSB first through an invert/+1 cell; when
// neg is 0 the carry starts at 0 and the value passes through unchanged, so
// the latency is identical either way.
module division_serial_negator #(
   parameter int WIDTH = division_pkg::DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr_q;
   logic             neg_q;
   logic             carry_q;
   logic             inv_s;
   logic             bit_s;

   // Conditional inversion of the current LSB, then the +1 ripple via carry.
   assign inv_s = sr_q[0] ^ neg_q;
   assign bit_s = inv_s ^ carry_q;

   // Shift register, negate flag and carry: load on start, rotate on shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q    <= {WIDTH{1'b0}};
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
      end else if (load) begin
         sr_q    <= din;
         neg_q   <= neg;
         carry_q <= neg;
      end else if (shift_en) begin
         sr_q    <= {bit_s, sr_q[WIDTH-1:1]};
         carry_q <= inv_s & carry_q;
      end else begin
         sr_q    <= sr_q;
         carry_q <= carry_q;
      end
   end

   assign dout = sr_q;

endmodule

// File: rtl/division_sign_restore.sv
// Re-applies operand signs to the divider's unsigned quotient/remainder.
// Quotient is negative when the operand signs differ; the remainder follows
// the dividend. Both results are negated serially in parallel lanes and
// handed over with a one-cycle finish pulse.
module division_sign_restore
   import division_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   division_sign_restore_if.slave  bus
);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_L    = {1'b1, {(WIDTH-1){1'b0}}};

   // A magnitude fits a signed WIDTH-bit result only up to MIN when negative
   // and below MIN when positive.
   function automatic logic ovf_f(input logic [WIDTH-1:0] mag, input logic neg);
      logic ovf;
      if (neg) begin
         ovf = (mag > MIN_L);
      end else begin
         ovf = (mag >= MIN_L);
      end
      return ovf;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_s;
   logic             shift_s;
   logic             neg_quot_s;
   logic [WIDTH-1:0] quot_dout_s;
   logic [WIDTH-1:0] rem_dout_s;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;
   logic             ovf_pend_q;
   logic             ovf_q;
   logic             busy_q;
   logic             fin_q;

   assign neg_quot_s = bus.first_sign ^ bus.second_sign;

   division_serial_negator #(.WIDTH(WIDTH)) u_quot_neg (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .shift_en (shift_s),
      .neg      (neg_quot_s),
      .din      (bus.quot_mag),
      .dout     (quot_dout_s)
   );

   division_serial_negator #(.WIDTH(WIDTH)) u_rem_neg (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .shift_en (shift_s),
      .neg      (bus.first_sign),
      .din      (bus.rem_mag),
      .dout     (rem_dout_s)
   );

   // Next-state, counter and lane control for the IDLE/SHIFT/DONE sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_s  = 1'b0;
      shift_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.restore_sel) begin
               load_s  = 1'b1;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_s = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM state and bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Overflow is decided from the start-edge magnitudes and published at DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_pend_q <= 1'b0;
      end else if (load_s) begin
         ovf_pend_q <= ovf_f(bus.quot_mag, neg_quot_s) | ovf_f(bus.rem_mag, bus.first_sign);
      end else begin
         ovf_pend_q <= ovf_pend_q;
      end
   end

   // Registered results, busy flag and the one-cycle finish pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quot_q <= {WIDTH{1'b0}};
         rem_q  <= {WIDTH{1'b0}};
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         fin_q  <= 1'b0;
      end else begin
         busy_q <= (state_d != ST_IDLE);
         if (state_q == ST_DONE) begin
            quot_q <= quot_dout_s;
            rem_q  <= rem_dout_s;
            ovf_q  <= ovf_pend_q;
            fin_q  <= 1'b1;
         end else begin
            fin_q  <= 1'b0;
         end
      end
   end

   assign bus.quotient       = quot_q;
   assign bus.remainder      = rem_q;
   assign bus.overflow       = ovf_q;
   assign bus.restore_busy   = busy_q;
   assign bus.restore_finish = fin_q;

endmodule

// File: tb/tb_division_sign_restore.sv
// Self-checking bench for division_sign_restore: directed sign cases,
// busy/abort behaviour and randomized passes against a signed-arithmetic model.
module tb_division_sign_restore;

   localparam int W = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;
   int   start_cyc;

   division_sign_restore_if #(.WIDTH(W)) bus ();

   division_sign_restore #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: signed value of a magnitude with a sign, truncated to W bits.
   function automatic logic [W-1:0] ref_val(input logic [W-1:0] m, input logic n);
      int v;
      v = n ? -int'(m) : int'(m);
      return W'(v);
   endfunction

   // Reference: representable range of a W-bit signed number is [-2^(W-1), 2^(W-1)-1].
   function automatic logic ref_ovf(input logic [W-1:0] m, input logic n);
      int v;
      v = n ? -int'(m) : int'(m);
      return (v < -(2 ** (W - 1))) || (v > (2 ** (W - 1)) - 1);
   endfunction

   task automatic start_pass(input logic [W-1:0] qm, input logic [W-1:0] rm,
                             input logic fs, input logic ss, input bit hold);
      @(negedge clk);
      bus.quot_mag    = qm;
      bus.rem_mag     = rm;
      bus.first_sign  = fs;
      bus.second_sign = ss;
      bus.restore_sel = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      check_eq("busy_after_start", 32'(bus.restore_busy), 32'd1);
      if (!hold) begin
         bus.restore_sel = 1'b0;
         bus.quot_mag    = W'($urandom);
         bus.rem_mag     = W'($urandom);
         bus.first_sign  = 1'($urandom);
         bus.second_sign = 1'($urandom);
      end
   endtask

   task automatic wait_finish(input logic [W-1:0] qm, input logic [W-1:0] rm,
                              input logic fs, input logic ss, input string tag);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         eo;
      bit           seen;
      eq = ref_val(qm, fs ^ ss);
      er = ref_val(rm, fs);
      eo = ref_ovf(qm, fs ^ ss) | ref_ovf(rm, fs);
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.restore_finish === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check_eq({tag, "_latency"}, 32'(cyc - start_cyc), 32'(W + 1));
         check_eq({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
         check_eq({tag, "_rem"}, 32'(bus.remainder), 32'(er));
         check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
         check_eq({tag, "_busy_done"}, 32'(bus.restore_busy), 32'd0);
         @(negedge clk);
         check_eq({tag, "_fin_pulse"}, 32'(bus.restore_finish), 32'd0);
         check_eq({tag, "_quot_hold"}, 32'(bus.quotient), 32'(eq));
      end
   endtask

   initial begin
      logic [W-1:0] qm;
      logic [W-1:0] rm;
      logic         fs;
      logic         ss;
      int           pulses;

      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b0;
      bus.restore_sel = 1'b0;
      bus.quot_mag    = '0;
      bus.rem_mag     = '0;
      bus.first_sign  = 1'b0;
      bus.second_sign = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_quot", 32'(bus.quotient), 32'd0);
      check_eq("rst_rem", 32'(bus.remainder), 32'd0);
      check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
      check_eq("rst_busy", 32'(bus.restore_busy), 32'd0);
      check_eq("rst_fin", 32'(bus.restore_finish), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Directed sign cases.
      start_pass(4'd3, 4'd1, 1'b1, 1'b0, 1'b0);
      wait_finish(4'd3, 4'd1, 1'b1, 1'b0, "m7_div_2");
      check_eq("m7_div_2_lit_q", 32'(bus.quotient), 32'hD);
      check_eq("m7_div_2_lit_r", 32'(bus.remainder), 32'hF);
      start_pass(4'd3, 4'd1, 1'b0, 1'b1, 1'b0);
      wait_finish(4'd3, 4'd1, 1'b0, 1'b1, "p7_div_m2");
      start_pass(4'd8, 4'd0, 1'b1, 1'b1, 1'b0);
      wait_finish(4'd8, 4'd0, 1'b1, 1'b1, "m8_div_m1");
      check_eq("m8_div_m1_lit_ovf", 32'(bus.overflow), 32'd1);
      start_pass(4'd8, 4'd0, 1'b1, 1'b0, 1'b0);
      wait_finish(4'd8, 4'd0, 1'b1, 1'b0, "m8_div_1");
      check_eq("m8_div_1_lit_ovf", 32'(bus.overflow), 32'd0);
      start_pass(4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      wait_finish(4'd0, 4'd0, 1'b1, 1'b0, "neg_zero");

      // Request while busy is ignored; results follow the first request.
      start_pass(4'd5, 4'd2, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.quot_mag    = 4'd1;
      bus.rem_mag     = 4'd1;
      bus.first_sign  = 1'b0;
      bus.second_sign = 1'b0;
      bus.restore_sel = 1'b1;
      @(negedge clk);
      bus.restore_sel = 1'b0;
      wait_finish(4'd5, 4'd2, 1'b1, 1'b0, "busy_ignore");
      repeat (3) @(negedge clk);
      check_eq("busy_not_queued", 32'(bus.restore_busy), 32'd0);

      // Request held high across DONE restarts on the following IDLE edge.
      start_pass(4'd6, 4'd3, 1'b0, 1'b1, 1'b1);
      wait_finish(4'd6, 4'd3, 1'b0, 1'b1, "held_first");
      check_eq("held_restart_busy", 32'(bus.restore_busy), 32'd1);
      bus.restore_sel = 1'b0;
      start_cyc = start_cyc + W + 2;
      wait_finish(4'd6, 4'd3, 1'b0, 1'b1, "held_second");

      // Reset during SHIFT aborts the pass.
      start_pass(4'd7, 4'd5, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_eq("abort_quot", 32'(bus.quotient), 32'd0);
      check_eq("abort_rem", 32'(bus.remainder), 32'd0);
      check_eq("abort_busy", 32'(bus.restore_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.restore_finish === 1'b1) pulses++;
      end
      check_eq("abort_no_finish", 32'(pulses), 32'd0);

      // Randomized passes.
      for (int n = 0; n < 40; n++) begin
         qm = W'($urandom);
         rm = W'($urandom);
         fs = 1'($urandom);
         ss = 1'($urandom);
         start_pass(qm, rm, fs, ss, 1'b0);
         wait_finish(qm, rm, fs, ss, "rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
